// File: rtl/mem_sram_pkg.sv
// rtl/mem_sram_pkg.sv - shared constants, request type and address helpers for the SRAM bank
package mem_sram_pkg;
   localparam int DEF_DATA_W = 256;
   localparam int DEF_DEPTH  = 1024;
   localparam int DEF_ADDR_W = 19;
   localparam int DEF_ID_W   = 4;
   localparam int DEF_RD_LAT = 1;

   typedef struct packed {
      logic                  write;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
      logic [DEF_DATA_W-1:0] wmask;
   } req_t;

   // Helpers work on a 64-bit view so any legal parameter set fits; callers cast down.
   function automatic logic [63:0] line_idx(input logic [63:0] addr, input int off_w,
                                            input int idx_w);
      return (addr >> off_w) & ((64'd1 << idx_w) - 64'd1);
   endfunction

   function automatic logic [63:0] bank_id(input logic [63:0] addr, input int addr_w,
                                           input int id_w);
      return (addr >> (addr_w - id_w)) & ((64'd1 << id_w) - 64'd1);
   endfunction
endpackage

// File: rtl/mem_sram_pipe_if.sv
// rtl/mem_sram_pipe_if.sv - request/response handshake bundle of the SRAM bank
interface mem_sram_pipe_if #(
   parameter int DATA_W = mem_sram_pkg::DEF_DATA_W,
   parameter int ADDR_W = mem_sram_pkg::DEF_ADDR_W
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0] req_wmask;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/mem_sram_array.sv
// rtl/mem_sram_array.sv - DEPTH x DATA_W storage with bit-masked write and registered read
module mem_sram_array
   import mem_sram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic [IDX_W-1:0]  addr,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] wmask,
   input  logic              re,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= (wdata & wmask) | (mem[addr] & ~wmask);
      if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/mem_sram_pipe.sv
// rtl/mem_sram_pipe.sv - SRAM bank with ID/range checking, masked writes and a stallable read pipeline
module mem_sram_pipe
   import mem_sram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int ID_W   = DEF_ID_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ID_W-1:0] id,
   mem_sram_pipe_if.slave  bus,
   output logic            err_sticky,
   output logic [7:0]      err_cnt
);
   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int RNG_W = ADDR_W - ID_W - IDX_W - OFF_W;

   logic                          stall, accept, reject;
   logic                          arr_we, arr_re;
   logic [63:0]                   addr64;
   logic [IDX_W-1:0]              idx;
   logic [DATA_W-1:0]             arr_rdata, s0_hold;
   logic                          s0_valid, s0_err, s0_fresh;
   logic [RD_LAT-1:0]             st_v, st_e;
   logic [RD_LAT-1:0][DATA_W-1:0] st_d;

   assign stall         = bus.rsp_valid && !bus.rsp_ready;
   assign bus.req_ready = !stall;
   assign accept        = bus.req_valid && !stall;
   assign addr64        = 64'(bus.req_addr);
   assign idx           = IDX_W'(line_idx(addr64, OFF_W, IDX_W));
   // Bits between the index and ID fields must be zero; RNG_W may be 0, giving an empty mask.
   assign reject = (bank_id(addr64, ADDR_W, ID_W) != 64'(id)) ||
                   (((addr64 >> (OFF_W + IDX_W)) & ((64'd1 << RNG_W) - 64'd1)) != 64'd0);
   assign arr_we = accept && bus.req_write && !reject;
   assign arr_re = accept && !bus.req_write && !reject;

   mem_sram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .addr  (idx),
      .we    (arr_we),
      .wdata (bus.req_wdata),
      .wmask (bus.req_wmask),
      .re    (arr_re),
      .rdata (arr_rdata)
   );

   // Stage 0 reads straight from the array the cycle after the read, then from s0_hold if stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid <= 1'b0;
         s0_err   <= 1'b0;
         s0_fresh <= 1'b0;
         s0_hold  <= '0;
      end else if (!stall) begin
         s0_valid <= accept && !bus.req_write;
         s0_err   <= accept && !bus.req_write && reject;
         s0_fresh <= arr_re;
      end else if (s0_fresh) begin
         s0_hold  <= arr_rdata;
         s0_fresh <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
         err_cnt    <= 8'd0;
      end else if (accept && reject) begin
         err_sticky <= 1'b1;
         if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

   assign st_v[0] = s0_valid;
   assign st_e[0] = s0_err;
   assign st_d[0] = s0_err ? '0 : (s0_fresh ? arr_rdata : s0_hold);

   for (genvar k = 1; k < RD_LAT; k++) begin : g_stage
      logic              v_q, e_q;
      logic [DATA_W-1:0] d_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            e_q <= 1'b0;
            d_q <= '0;
         end else if (!stall) begin
            v_q <= st_v[k-1];
            e_q <= st_e[k-1];
            d_q <= st_d[k-1];
         end
      end

      assign st_v[k] = v_q;
      assign st_e[k] = e_q;
      assign st_d[k] = d_q;
   end

   assign bus.rsp_valid = st_v[RD_LAT-1];
   assign bus.rsp_err   = st_e[RD_LAT-1];
   assign bus.rsp_data  = st_d[RD_LAT-1];
endmodule

// File: doc/mem_sram_pipe.md
# mem_sram_pipe

Parametrised single-port SRAM bank with a valid/ready request port, bit-masked writes, a configurable read-latency pipeline with response backpressure, and bank-ID / range checking. It is the next-generation bank memory used by the Mannix memory subsystem: each bank instance owns one ID slice of the global address space. Mismatched or out-of-range requests are reported through an error response instead of being written or read.

## Interface
Parameters:
- DATA_W, 256, line width in bits (multiple of 8)
- DEPTH, 1024, number of lines (power of 2)
- ADDR_W, 19, global byte-address width
- ID_W, 4, bank-ID width; ID field is addr[ADDR_W-1 -: ID_W]
- RD_LAT, 1, read latency in cycles, legal 1..3

Derived: OFF_W = log2(DATA_W/8) byte-offset bits; IDX_W = log2(DEPTH); line index = addr[OFF_W +: IDX_W].

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id  in  ID_W  this bank's ID, static after reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wmask  in  DATA_W  per-bit write enable
- rsp_valid  out  1  read response present
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_data  out  DATA_W  read data (0 on error)
- rsp_err  out  1  response belongs to a rejected read
- err_sticky  out  1  set on any rejected request, cleared only by reset
- err_cnt  out  8  rejected-request count, saturates at 255

## Operation
- A request is rejected when the ID field != id, or when the address bits between index and ID fields are nonzero (out of range for DEPTH).
- Accepted write: line <= (wdata & wmask) | (line & ~wmask); no response is generated; a mask of all zeros leaves the line unchanged.
- Accepted read: one response enters the RD_LAT-deep pipeline carrying the line data, err = 0.
- Rejected write: array untouched; err_sticky set; err_cnt++.
- Rejected read: array untouched; a response with rsp_err = 1 and rsp_data = 0 enters the pipeline; err_sticky set; err_cnt++.
- Stall = rsp_valid && !rsp_ready. While stalled, every pipeline stage holds its contents.
- req_ready = !stall, so both reads and writes are blocked. When not stalled, the port accepts one request per cycle.
- Responses are returned strictly in request order.

## Timing
- Reset (asynchronous): rsp_valid = 0, rsp_err = 0, rsp_data = 0, err_sticky = 0, err_cnt = 0, all pipeline valid bits = 0. req_ready = 1 after reset. Array contents are not reset.
- Reset asserted mid-operation drops all in-flight reads; no response is produced for them.
- Read accepted at edge N: rsp_valid is high after edge N+RD_LAT-1, plus any stall cycles.
- Write accepted at edge N: a read accepted at edge N+1 to the same line returns the new data.
- err_cnt updates at the acceptance edge.
- req_ready is combinational from rsp_valid and rsp_ready; there is no other comb path from inputs to outputs.

## Structure
- Package mem_sram_pkg holds:
  - default parameter constants
  - a req_t struct (write, addr, wdata, wmask)
  - functions line_idx() and bank_id()
- Sub-module mem_sram_array: pure storage, DEPTH×DATA_W, one masked-write port and one registered-read port with a read enable, no reset. mem_sram_pipe instantiates it and keeps the data of a stalled stage 0 in its own register.
- Pipeline stages 1..RD_LAT-1 are built with a generate loop.

## Test plan
- Full-mask write of 0xA5…A5 to line 3, then read line 3 with RD_LAT = 2 → rsp_valid exactly 2 cycles after acceptance, data 0xA5…A5, rsp_err = 0.
- Line 3 = all ones; write wdata = 0 with mask = low 128 bits set → read returns upper 128 bits ones, lower 128 bits zero.
- Read with ID field = id+1 → rsp_err = 1, rsp_data = 0, err_sticky = 1, err_cnt = 1. 300 rejected requests → err_cnt = 255.
- Back-to-back reads of lines 0..7 with rsp_ready held low for 5 cycles mid-stream → req_ready low while stalled, all 8 responses in order, none lost or duplicated.
- Write line 5 at edge N, read line 5 at edge N+1 → new data returned.
- Assert rst_n with 2 reads in flight → rsp_valid = 0 immediately. Array data written before reset is still readable afterwards.
